// File: rtl/sram_responder.sv
// sram_responder
//   Single-port 32-bit word SRAM on the responder side of the SRAM bus.
//   Each access is latched when chip-select is first seen low. WAIT_STATES
//   extra cycles follow, then the access commits and sram_ready pulses
//   for one cycle. Reads return registered data in that same cycle.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   sram_addr   in   word address (ADDR_W bits)
//   sram_wdata  in   write data
//   sram_rdata  out  registered read data; holds the last word read
//   sram_cs_n   in   chip select, active-low
//   sram_we_n   in   0 = write, 1 = read
//   sram_be_n   in   byte enables, active-low (writes only)
//   sram_ready  out  one-cycle access-complete pulse
module sram_responder #(
  parameter int    ADDR_W      = 13,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_wdata,
  output logic [31:0]       sram_rdata,
  input  logic              sram_cs_n,
  input  logic              sram_we_n,
  input  logic [3:0]        sram_be_n,
  output logic              sram_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [31:0]       mem [0:(2**ADDR_W)-1];

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              we_q;
  logic              ready_q;
  logic [31:0]       rdata_q;
  logic              latch;
  logic              commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!sram_cs_n) begin
          latch   = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sram_cs_n) begin
          // Initiator withdrew: drop the access, nothing is committed.
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '1;
      we_q    <= 1'b1;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= commit;
      if (latch) begin
        addr_q  <= sram_addr;
        wdata_q <= sram_wdata;
        be_q    <= sram_be_n;
        we_q    <= sram_we_n;
      end
      if (commit && we_q) begin
        rdata_q <= mem[addr_q];
      end
    end
  end

  // The commit strobe is derived from state_q, which reset forces to IDLE,
  // so a write whose commit edge falls inside reset never lands.
  always_ff @(posedge clk) begin
    if (commit && !we_q) begin
      if (!be_q[0]) mem[addr_q][7:0]   <= wdata_q[7:0];
      if (!be_q[1]) mem[addr_q][15:8]  <= wdata_q[15:8];
      if (!be_q[2]) mem[addr_q][23:16] <= wdata_q[23:16];
      if (!be_q[3]) mem[addr_q][31:24] <= wdata_q[31:24];
    end
  end

  assign sram_rdata = rdata_q;
  assign sram_ready = ready_q;

endmodule
